instr_fetch_unit: RTL and testbench



---
 rtl/armv8_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/armv8_pkg.sv
// Shared widths and the fetch-buffer entry layout for the ARMv8 front end.
package armv8_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;
  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

  typedef struct packed {
    logic               valid;
    logic               filled;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Circular fetch buffer: entries allocated at issue, filled in order by
// memory responses, and popped at the head by the decode handshake.
module fetch_buffer
  import armv8_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_alloc,
  input  logic [ADDR_W-1:0]  i_alloc_pc,
  input  logic               i_fill,
  input  logic [INSTR_W-1:0] i_fill_data,
  input  logic               i_pop,
  output logic [PTR_W:0]     o_count,
  output logic [PTR_W:0]     o_unfilled,
  output logic               o_head_filled,
  output logic [ADDR_W-1:0]  o_head_pc,
  output logic [INSTR_W-1:0] o_head_instr
);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  fetch_entry_t     r_entries [DEPTH];
  logic [PTR_W:0]   r_alloc_ptr;
  logic [PTR_W:0]   r_fill_ptr;
  logic [PTR_W:0]   r_read_ptr;
  logic [PTR_W-1:0] w_alloc_idx;
  logic [PTR_W-1:0] w_fill_idx;
  logic [PTR_W-1:0] w_read_idx;

  assign w_alloc_idx = r_alloc_ptr[PTR_W-1:0];
  assign w_fill_idx  = r_fill_ptr[PTR_W-1:0];
  assign w_read_idx  = r_read_ptr[PTR_W-1:0];

  // Pointers carry one extra wrap bit so full and empty differ.
  assign o_count       = r_alloc_ptr - r_read_ptr;
  assign o_unfilled    = r_alloc_ptr - r_fill_ptr;
  assign o_head_filled = r_entries[w_read_idx].valid && r_entries[w_read_idx].filled;
  assign o_head_pc     = r_entries[w_read_idx].pc;
  assign o_head_instr  = r_entries[w_read_idx].instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entries   <= '{default: '0};
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_read_ptr  <= '0;
    end else if (i_flush) begin
      r_entries   <= '{default: '0};
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_read_ptr  <= '0;
    end else begin
      if (i_alloc) begin
        r_entries[w_alloc_idx] <= '{valid: 1'b1, filled: 1'b0, pc: i_alloc_pc, instr: '0};
        r_alloc_ptr            <= r_alloc_ptr + PTR_ONE;
      end
      if (i_fill) begin
        r_entries[w_fill_idx].filled <= 1'b1;
        r_entries[w_fill_idx].instr  <= i_fill_data;
        r_fill_ptr                   <= r_fill_ptr + PTR_ONE;
      end
      if (i_pop) begin
        r_entries[w_read_idx].valid  <= 1'b0;
        r_entries[w_read_idx].filled <= 1'b0;
        r_read_ptr                   <= r_read_ptr + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, request issue, redirect handling and the
// discard counter for responses to requests flushed by a taken branch.
module instr_fetch_unit
  import armv8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 64'h0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_discard;
  logic [CNT_W-1:0]  w_discard_nxt;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_unfilled;
  logic [CNT_W-1:0]  w_inflight;
  logic              w_issue;
  logic              w_fill;
  logic              w_pop;
  logic              w_head_filled;
  logic              w_unused_tgt_lsb;

  assign w_unused_tgt_lsb = ^branch_target[1:0];

  assign w_inflight  = w_count + r_discard;
  assign imem_req    = (w_inflight < CNT_W'(BUF_DEPTH)) && !branch_taken && rst_n;
  assign imem_addr   = r_pc;
  assign w_issue     = imem_req && imem_ready;
  assign w_fill      = imem_rvalid && (r_discard == '0) && !branch_taken;
  assign instr_valid = w_head_filled && !branch_taken;
  assign w_pop       = instr_valid && instr_ready;

  // A response arriving with the redirect retires the oldest outstanding
  // request, whether that one was already being discarded or not.
  always_comb begin
    w_discard_nxt = r_discard;
    if (branch_taken) begin
      w_discard_nxt = r_discard + w_unfilled - CNT_W'(imem_rvalid);
    end else if (imem_rvalid && (r_discard != '0)) begin
      w_discard_nxt = r_discard - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_discard <= '0;
    end else begin
      r_discard <= w_discard_nxt;
      if (branch_taken) begin
        r_pc <= {branch_target[ADDR_W-1:2], 2'b00};
      end else if (w_issue) begin
        r_pc <= r_pc + PC_INC;
      end
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_fetch_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (branch_taken),
    .i_alloc      (w_issue),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_fill),
    .i_fill_data  (imem_rdata),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled),
    .o_head_filled(w_head_filled),
    .o_head_pc    (instr_pc),
    .o_head_instr (instr)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable memory model.
module tb_instr_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int unsigned DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  int          vec = 0;
  int          err = 0;
  int unsigned mem_lat = 1;
  int unsigned cyc = 0;

  logic [63:0] pend_addr[$];
  int unsigned pend_due[$];
  logic [63:0] iss_log[$];
  int unsigned iss_cyc[$];
  logic [63:0] opc_log[$];
  logic [31:0] oin_log[$];
  int unsigned ocyc_log[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Memory model and output monitor, both sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend_addr.delete(); pend_due.delete();
        imem_rvalid = 1'b0; imem_rdata = '0;
      end else begin
        if (imem_req && imem_ready) begin
          pend_addr.push_back(imem_addr); pend_due.push_back(cyc + mem_lat);
          iss_log.push_back(imem_addr); iss_cyc.push_back(cyc);
        end
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
          imem_rvalid = 1'b1; imem_rdata = word_at(pend_addr[0]);
          void'(pend_addr.pop_front()); void'(pend_due.pop_front());
        end else begin
          imem_rvalid = 1'b0; imem_rdata = '0;
        end
        if (instr_valid && instr_ready) begin
          opc_log.push_back(instr_pc); oin_log.push_back(instr); ocyc_log.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    iss_log.delete(); iss_cyc.delete(); opc_log.delete(); oin_log.delete(); ocyc_log.delete();
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst_n = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (imem_req !== 1'b0) begin err++; $display("FAIL rst_req: got %0h expected 0", imem_req); end
    vec++; if (imem_addr !== 64'h1000) begin err++; $display("FAIL rst_addr: got %h expected 1000", imem_addr); end
    vec++; if (instr_valid !== 1'b0) begin err++; $display("FAIL rst_valid: got %0h expected 0", instr_valid); end
    vec++; if (instr !== 32'h0) begin err++; $display("FAIL rst_instr: got %h expected 0", instr); end
    vec++; if (instr_pc !== 64'h0) begin err++; $display("FAIL rst_pc: got %h expected 0", instr_pc); end
    @(posedge clk); #1 rst_n = 1'b1; clear_logs();
    @(negedge clk);
    vec++; if (imem_req !== 1'b1) begin err++; $display("FAIL first_req: got %0h expected 1", imem_req); end
    vec++; if (imem_addr !== 64'h1000) begin err++; $display("FAIL first_addr: got %h expected 1000", imem_addr); end
  endtask

  task automatic test_stream();
    repeat (8) tick();
    vec++; if (iss_log.size() < 3) begin err++; $display("FAIL stream_issues: got %0d expected >=3", iss_log.size()); end
    for (int i = 0; i < 3 && i < iss_log.size(); i++) begin
      vec++; if (iss_log[i] !== 64'h1000 + 64'(4 * i)) begin err++; $display("FAIL stream_addr%0d: got %h expected %h", i, iss_log[i], 64'h1000 + 64'(4 * i)); end
    end
    for (int i = 1; i < 3 && i < iss_cyc.size(); i++) begin
      vec++; if (iss_cyc[i] !== iss_cyc[i-1] + 1) begin err++; $display("FAIL stream_issue_gap%0d: got %0d expected %0d", i, iss_cyc[i], iss_cyc[i-1] + 1); end
    end
    vec++; if (opc_log.size() < 5) begin err++; $display("FAIL stream_outs: got %0d expected >=5", opc_log.size()); end
    for (int i = 0; i < 5 && i < opc_log.size(); i++) begin
      vec++; if (opc_log[i] !== 64'h1000 + 64'(4 * i)) begin err++; $display("FAIL stream_pc%0d: got %h expected %h", i, opc_log[i], 64'h1000 + 64'(4 * i)); end
      vec++; if (oin_log[i] !== word_at(64'h1000 + 64'(4 * i))) begin err++; $display("FAIL stream_instr%0d: got %h expected %h", i, oin_log[i], word_at(64'h1000 + 64'(4 * i))); end
      if (i > 0) begin
        vec++; if (ocyc_log[i] !== ocyc_log[i-1] + 1) begin err++; $display("FAIL stream_out_gap%0d: got %0d expected %0d", i, ocyc_log[i], ocyc_log[i-1] + 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0; reset_dut(); clear_logs();
    repeat (10) tick();
    vec++; if (iss_log.size() !== DEPTH) begin err++; $display("FAIL bp_issue_count: got %0d expected %0d", iss_log.size(), DEPTH); end
    vec++; if (imem_req !== 1'b0) begin err++; $display("FAIL bp_req_full: got %0h expected 0", imem_req); end
    vec++; if (instr_valid !== 1'b1) begin err++; $display("FAIL bp_head_valid: got %0h expected 1", instr_valid); end
    vec++; if (opc_log.size() !== 0) begin err++; $display("FAIL bp_no_pop: got %0d expected 0", opc_log.size()); end
    instr_ready = 1'b1;
    repeat (12) tick();
    vec++; if (opc_log.size() < 8) begin err++; $display("FAIL bp_outs: got %0d expected >=8", opc_log.size()); end
    for (int i = 0; i < 8 && i < opc_log.size(); i++) begin
      vec++; if (opc_log[i] !== 64'h1000 + 64'(4 * i)) begin err++; $display("FAIL bp_pc%0d: got %h expected %h", i, opc_log[i], 64'h1000 + 64'(4 * i)); end
      vec++; if (oin_log[i] !== word_at(64'h1000 + 64'(4 * i))) begin err++; $display("FAIL bp_instr%0d: got %h expected %h", i, oin_log[i], word_at(64'h1000 + 64'(4 * i))); end
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b1; mem_lat = 3; reset_dut(); clear_logs();
    tick(); tick();
    branch_taken = 1'b1; branch_target = 64'h2002;
    @(negedge clk);
    vec++; if (imem_req !== 1'b0) begin err++; $display("FAIL redir_req_blocked: got %0h expected 0", imem_req); end
    vec++; if (instr_valid !== 1'b0) begin err++; $display("FAIL redir_valid_blocked: got %0h expected 0", instr_valid); end
    tick(); branch_taken = 1'b0;
    @(negedge clk);
    vec++; if (imem_req !== 1'b1) begin err++; $display("FAIL redir_req: got %0h expected 1", imem_req); end
    vec++; if (imem_addr !== 64'h2000) begin err++; $display("FAIL redir_addr: got %h expected 2000", imem_addr); end
    repeat (8) tick();
    vec++; if (iss_log.size() < 3 || iss_log[2] !== 64'h2000) begin err++; $display("FAIL redir_issue_seq: got %0d issues, expected third issue at 2000", iss_log.size()); end
    vec++; if (opc_log.size() < 2) begin err++; $display("FAIL redir_outs: got %0d expected >=2", opc_log.size()); end
    else begin
      vec++; if (opc_log[0] !== 64'h2000) begin err++; $display("FAIL redir_pc0: got %h expected 2000", opc_log[0]); end
      vec++; if (oin_log[0] !== 32'hC0DE_2000) begin err++; $display("FAIL redir_instr0: got %h expected c0de2000", oin_log[0]); end
      vec++; if (opc_log[1] !== 64'h2004) begin err++; $display("FAIL redir_pc1: got %h expected 2004", opc_log[1]); end
    end
    mem_lat = 1;
  endtask

  task automatic test_coincident();
    bit seen;
    instr_ready = 1'b1; mem_lat = 1; reset_dut(); clear_logs();
    repeat (4) tick();
    branch_taken = 1'b1; branch_target = 64'h3000; clear_logs();
    @(negedge clk);
    vec++; if (instr_valid !== 1'b0) begin err++; $display("FAIL coinc_valid: got %0h expected 0", instr_valid); end
    vec++; if (instr_pc !== 64'h1008) begin err++; $display("FAIL coinc_head_pc: got %h expected 1008", instr_pc); end
    tick(); branch_taken = 1'b0;
    repeat (6) tick();
    seen = 1'b0;
    foreach (opc_log[i]) if (opc_log[i] == 64'h1008 || opc_log[i] == 64'h100C) seen = 1'b1;
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL coinc_voided: got %0d expected 0", seen); end
    vec++; if (opc_log.size() < 2) begin err++; $display("FAIL coinc_outs: got %0d expected >=2", opc_log.size()); end
    else begin
      vec++; if (opc_log[0] !== 64'h3000) begin err++; $display("FAIL coinc_pc0: got %h expected 3000", opc_log[0]); end
      vec++; if (oin_log[0] !== 32'hC0DE_3000) begin err++; $display("FAIL coinc_instr0: got %h expected c0de3000", oin_log[0]); end
      vec++; if (opc_log[1] !== 64'h3004) begin err++; $display("FAIL coinc_pc1: got %h expected 3004", opc_log[1]); end
    end
  endtask

  task automatic test_mem_stall();
    imem_ready = 1'b0; reset_dut(); clear_logs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++; if (imem_addr !== 64'h1000) begin err++; $display("FAIL stall_addr%0d: got %h expected 1000", i, imem_addr); end
    end
    tick(); imem_ready = 1'b1;
    repeat (6) tick();
    vec++; if (iss_log.size() < 2 || iss_log[0] !== 64'h1000 || iss_log[1] !== 64'h1004) begin err++; $display("FAIL stall_resume: got %0d issues, expected 1000 then 1004", iss_log.size()); end
    vec++; if (opc_log.size() < 1 || opc_log[0] !== 64'h1000) begin err++; $display("FAIL stall_out0: got %0d outputs, expected first at 1000", opc_log.size()); end
  endtask

  task automatic test_wrap();
    imem_ready = 1'b1; instr_ready = 1'b1; reset_dut();
    tick();
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFE; clear_logs();
    tick(); branch_taken = 1'b0;
    @(negedge clk);
    vec++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin err++; $display("FAIL wrap_addr0: got %h expected fffffffffffffffc", imem_addr); end
    repeat (6) tick();
    vec++; if (iss_log.size() < 3) begin err++; $display("FAIL wrap_issues: got %0d expected >=3", iss_log.size()); end
    else begin
      vec++; if (iss_log[1] !== 64'h0) begin err++; $display("FAIL wrap_addr1: got %h expected 0", iss_log[1]); end
      vec++; if (iss_log[2] !== 64'h4) begin err++; $display("FAIL wrap_addr2: got %h expected 4", iss_log[2]); end
    end
    vec++; if (opc_log.size() < 2) begin err++; $display("FAIL wrap_outs: got %0d expected >=2", opc_log.size()); end
    else begin
      vec++; if (oin_log[0] !== 32'h3F21_FFFC) begin err++; $display("FAIL wrap_instr0: got %h expected 3f21fffc", oin_log[0]); end
      vec++; if (opc_log[1] !== 64'h0) begin err++; $display("FAIL wrap_pc1: got %h expected 0", opc_log[1]); end
      vec++; if (oin_log[1] !== 32'hC0DE_0000) begin err++; $display("FAIL wrap_instr1: got %h expected c0de0000", oin_log[1]); end
    end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b0; reset_dut();
    repeat (8) tick();
    vec++; if (instr_valid !== 1'b1) begin err++; $display("FAIL areset_pre_valid: got %0h expected 1", instr_valid); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (instr_valid !== 1'b0) begin err++; $display("FAIL areset_valid: got %0h expected 0", instr_valid); end
    vec++; if (imem_req !== 1'b0) begin err++; $display("FAIL areset_req: got %0h expected 0", imem_req); end
    vec++; if (instr_pc !== 64'h0) begin err++; $display("FAIL areset_pc: got %h expected 0", instr_pc); end
    vec++; if (imem_addr !== 64'h1000) begin err++; $display("FAIL areset_addr: got %h expected 1000", imem_addr); end
    @(posedge clk); #1 rst_n = 1'b1; instr_ready = 1'b1; clear_logs();
    @(negedge clk);
    vec++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin err++; $display("FAIL areset_restart: got req %0h addr %h expected req 1 addr 1000", imem_req, imem_addr); end
    repeat (6) tick();
    vec++; if (opc_log.size() < 1 || opc_log[0] !== 64'h1000) begin err++; $display("FAIL areset_out0: got %0d outputs, expected first at 1000", opc_log.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_coincident();
    test_mem_stall();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
